tof_frame_collector: RTL and testbench
======================================

Name: tof_frame_collector

Overview:
- Parametrised successor to the single-BRAM sensor capture path.
- Collects per-zone distance samples from N ToF sensors into a double-buffered (ping-pong) frame memory.
- Closes a frame when every enabled sensor has delivered its last zone, or when a timeout expires.
- Hands the completed bank to downstream consumers (surface/plane calculators) through a valid/ack handshake, while the other bank keeps filling.

Parameters:
- N_SENS, 8, number of ToF sensors.
- ZONES, 64, zones per sensor (power of 2).
- DW, 16, distance sample width (mm).
- TIMEOUT, 2000000, clk cycles from first accepted write to forced frame close; 0 disables the timeout.
- SW, $clog2(N_SENS), sensor index width (derived).
- ZW, $clog2(ZONES), zone index width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  sample strobe.
- s_ready  out  1  collector can accept a sample.
- s_sensor  in  SW  sensor index of the sample.
- s_zone  in  ZW  zone index of the sample.
- s_data  in  DW  distance value.
- sens_mask  in  N_SENS  enabled sensors; latched at frame start.
- frm_valid  out  1  completed frame available in the read bank.
- frm_ack  in  1  consumer has finished with the read bank.
- frm_missing  out  N_SENS  sensors not complete when the frame closed (nonzero only on timeout).
- frm_seq  out  16  frame sequence number, wraps at 0xFFFF->0.
- rd_addr  in  SW+ZW  read address, {sensor, zone}.
- rd_data  out  DW  read-bank data.
- drop_cnt  out  16  discarded samples; saturates at 0xFFFF.

Behaviour:
- Reset (async, rst_n=0) values:
  - frm_valid=0, frm_missing=0, frm_seq=0, rd_data=0, drop_cnt=0.
  - s_ready=1, write bank wb=0, state IDLE, done flags cleared, timeout counter 0.
  - Memory contents are undefined.
- Reset mid-frame abandons the partial frame.
- A sample is accepted when s_valid & s_ready.
- Memory: 2*N_SENS*ZONES words, one write port and one read port.
  - Write address {wb, s_sensor, s_zone}.
  - Read address {~wb, rd_addr}.
  - rd_data is registered: 1-cycle latency.
  - The read bank is stable while frm_valid=1.
- States:
  - IDLE: waits for an accepted sample whose sensor bit is set in sens_mask.
    - On that sample: latch mask_q=sens_mask, write the sample, clear the timeout counter, go to FILL.
    - If sens_mask=0, every sample is dropped and the block stays in IDLE.
  - FILL: writes each accepted sample whose sensor is in mask_q and whose done flag is clear.
    - A write with s_zone==ZONES-1 sets done[s_sensor].
    - Samples to unmasked or already-done sensors are dropped (drop_cnt+1).
    - The timeout counter increments every cycle.
    - Close condition: (done|~mask_q)==all-ones, evaluated including this cycle's write. Missing = 0.
    - Timeout condition: TIMEOUT!=0 and counter==TIMEOUT-1. Missing = mask_q & ~done.
    - Completion and timeout in the same cycle: completion wins, missing=0.
    - On close: go to SWAP if (frm_valid==0 | frm_ack), otherwise go to HOLD.
  - HOLD: s_ready=0; waits for frm_ack; then SWAP.
  - SWAP (1 cycle): s_ready=0; wb toggles; frm_valid=1; frm_missing=captured missing; frm_seq+1; done cleared; go to IDLE.
- frm_valid clears on the cycle after frm_ack is sampled high, unless SWAP sets it again in that cycle (SWAP has priority).
- frm_ack while frm_valid=0 is ignored.
- s_ready is 1 in IDLE and FILL, and 0 in HOLD and SWAP.
- A sample presented while s_ready=0 is not accepted and is not counted.
- Latency: last required write at cycle t gives frm_valid=1 at cycle t+2 when the read bank is free.

Decomposition:
- Package tof_frame_pkg:
  - state enum (IDLE, FILL, HOLD, SWAP).
  - localparams for default N_SENS/ZONES/DW.
  - address-packing function {bank, sensor, zone}.
- One sub-module, tof_frame_ram: simple dual-port RAM, DEPTH=2*N_SENS*ZONES, registered read, inferred as BRAM.
- Control FSM, done flags, timeout counter and counters stay in tof_frame_collector.

Test Plan:
- N_SENS=8, ZONES=64, mask=0xFF; write all 512 samples in order with data={sensor,zone} -> frm_valid 2 cycles after sample (7,63), frm_missing=0, frm_seq=1; reading addr 0x1C5 returns 0x0705 one cycle later.
- Frame 1 left unacked; frame 2 completes -> s_ready=0 (HOLD); assert frm_ack -> SWAP, frm_valid remains 1, frm_seq=2, s_ready=1 again.
- mask=0x0F, TIMEOUT=1000; sensors 0-2 complete, sensor 3 delivers zones 0-10 only -> frame closes at cycle 1000 after first write, frm_missing=0x08.
- mask=0x01; send sensor 4 samples, then sensor 0 zone 63 twice -> drop_cnt increments for each sensor-4 sample plus the duplicate; frame closes once.
- Final zone write and timeout expiry land on the same cycle -> frm_missing=0.
- Pull rst_n low mid-FILL for 1 cycle -> all outputs return to reset values asynchronously; the next full frame produces frm_seq=1.

Source files
------------

// File: rtl/tof_frame_pkg.sv
// ---------------------------------------------------------------------------
// tof_frame_pkg
// Shared definitions for the ToF frame collector:
//   - state_t   : control FSM states
//   - DEF_*     : default geometry / timing parameters
//   - pack_addr : builds the flat frame-memory address {bank, sensor, zone}
// ---------------------------------------------------------------------------
package tof_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2,
        ST_SWAP = 2'd3
    } state_t;

    localparam int DEF_N_SENS  = 8;
    localparam int DEF_ZONES   = 64;
    localparam int DEF_DW      = 16;
    localparam int DEF_TIMEOUT = 2000000;

    // Concatenates bank, sensor and zone into one address. The result is
    // 32 bits wide; callers size-cast it to their own address width.
    function automatic logic [31:0] pack_addr(
        input logic        bank,
        input logic [15:0] sensor,
        input logic [15:0] zone,
        input int          sw,
        input int          zw
    );
        return (32'(bank) << (sw + zw)) | (32'(sensor) << zw) | 32'(zone);
    endfunction

endpackage

// File: rtl/tof_frame_ram.sv
// ---------------------------------------------------------------------------
// tof_frame_ram
// Simple dual-port frame memory: one write port, one read port, registered
// read (1-cycle latency). No reset on the array or read register so the
// storage maps onto block RAM.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data, valid one cycle after rd_addr
// ---------------------------------------------------------------------------
module tof_frame_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/tof_frame_collector.sv
// ---------------------------------------------------------------------------
// tof_frame_collector
// Collects per-zone distance samples from N_SENS ToF sensors into a
// ping-pong frame memory. A frame closes when every enabled sensor has
// delivered its last zone, or when TIMEOUT cycles elapse after the first
// write. The closed bank is handed to the consumer with frm_valid/frm_ack
// while the other bank fills.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : sample handshake
//   s_sensor/s_zone   : sample position, s_data : distance value
//   sens_mask         : enabled sensors, latched on the first write of a frame
//   frm_valid/frm_ack : completed-frame handshake
//   frm_missing       : sensors incomplete at close (timeout only)
//   frm_seq           : frame sequence number
//   rd_addr/rd_data   : read port into the completed bank, 1-cycle latency
//   drop_cnt          : saturating count of discarded samples
// ---------------------------------------------------------------------------
module tof_frame_collector
    import tof_frame_pkg::*;
#(
    parameter int N_SENS  = DEF_N_SENS,
    parameter int ZONES   = DEF_ZONES,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int SW      = $clog2(N_SENS),
    parameter int ZW      = $clog2(ZONES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [SW-1:0]     s_sensor,
    input  logic [ZW-1:0]     s_zone,
    input  logic [DW-1:0]     s_data,
    input  logic [N_SENS-1:0] sens_mask,
    output logic              frm_valid,
    input  logic              frm_ack,
    output logic [N_SENS-1:0] frm_missing,
    output logic [15:0]       frm_seq,
    input  logic [SW+ZW-1:0]  rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic [15:0]       drop_cnt
);

    localparam int AW = 1 + SW + ZW;
    // Equals 2*N_SENS*ZONES for a power-of-two sensor count; rounding up
    // otherwise keeps the packed {bank,sensor,zone} address always in range.
    localparam int DEPTH = 1 << AW;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ZW-1:0] LAST_ZONE = ZW'(ZONES - 1);
    localparam logic [SW-1:0] LAST_SENS = SW'(N_SENS - 1);

    state_t              state_q, state_d;
    logic                wb_q, wb_d;
    logic [N_SENS-1:0]   mask_q, mask_d;
    logic [N_SENS-1:0]   done_q, done_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [N_SENS-1:0]   miss_cap_q, miss_cap_d;
    logic                frm_valid_q, frm_valid_d;
    logic [N_SENS-1:0]   frm_missing_q, frm_missing_d;
    logic [15:0]         frm_seq_q, frm_seq_d;
    logic [15:0]         drop_q, drop_d;
    logic                rd_primed_q;

    logic                accept;
    logic                sens_ok;
    logic                wr_en;
    logic                drop_inc;
    logic                frame_full;
    logic                tmo_hit;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       ram_rd_addr;
    logic [DW-1:0]       ram_rd_data;

    assign s_ready = (state_q == ST_IDLE) || (state_q == ST_FILL);
    assign accept  = s_valid && s_ready;
    // Guards against sensor indices beyond N_SENS when it is not a power of 2.
    assign sens_ok = (s_sensor <= LAST_SENS);

    assign wr_addr     = AW'(pack_addr(wb_q, 16'(s_sensor), 16'(s_zone), SW, ZW));
    assign ram_rd_addr = AW'(pack_addr(~wb_q, 16'(rd_addr[SW+ZW-1:ZW]),
                                       16'(rd_addr[ZW-1:0]), SW, ZW));

    always_comb begin
        state_d       = state_q;
        wb_d          = wb_q;
        mask_d        = mask_q;
        done_d        = done_q;
        tmo_d         = tmo_q;
        miss_cap_d    = miss_cap_q;
        frm_valid_d   = frm_valid_q;
        frm_missing_d = frm_missing_q;
        frm_seq_d     = frm_seq_q;
        drop_d        = drop_q;
        wr_en         = 1'b0;
        drop_inc      = 1'b0;
        frame_full    = 1'b0;
        tmo_hit       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sens_ok && sens_mask[s_sensor]) begin
                        wr_en  = 1'b1;
                        mask_d = sens_mask;
                        tmo_d  = '0;
                        if (s_zone == LAST_ZONE) begin
                            done_d[s_sensor] = 1'b1;
                        end
                        state_d = ST_FILL;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                tmo_d = tmo_q + 1'b1;
                if (accept) begin
                    if (sens_ok && mask_q[s_sensor] && !done_q[s_sensor]) begin
                        wr_en = 1'b1;
                        if (s_zone == LAST_ZONE) begin
                            done_d[s_sensor] = 1'b1;
                        end
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                // done_d already includes this cycle's write, so the frame
                // closes in the same cycle as its final sample.
                frame_full = &(done_d | ~mask_q);
                tmo_hit    = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
                if (frame_full || tmo_hit) begin
                    // Completion takes priority over a coincident timeout.
                    miss_cap_d = frame_full ? '0 : (mask_q & ~done_d);
                    state_d    = (!frm_valid_q || frm_ack) ? ST_SWAP : ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (frm_ack) begin
                    state_d = ST_SWAP;
                end
            end

            ST_SWAP: begin
                wb_d          = ~wb_q;
                frm_missing_d = miss_cap_q;
                frm_seq_d     = frm_seq_q + 16'd1;
                done_d        = '0;
                state_d       = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (drop_inc && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        // An ack normally drops frm_valid; when it releases a pending swap
        // the flag is held so the consumer sees no gap before the new frame.
        if (frm_valid_q && frm_ack && (state_d != ST_SWAP)) begin
            frm_valid_d = 1'b0;
        end
        if (state_q == ST_SWAP) begin
            frm_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wb_q          <= 1'b0;
            mask_q        <= '0;
            done_q        <= '0;
            tmo_q         <= '0;
            miss_cap_q    <= '0;
            frm_valid_q   <= 1'b0;
            frm_missing_q <= '0;
            frm_seq_q     <= '0;
            drop_q        <= '0;
            rd_primed_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wb_q          <= wb_d;
            mask_q        <= mask_d;
            done_q        <= done_d;
            tmo_q         <= tmo_d;
            miss_cap_q    <= miss_cap_d;
            frm_valid_q   <= frm_valid_d;
            frm_missing_q <= frm_missing_d;
            frm_seq_q     <= frm_seq_d;
            drop_q        <= drop_d;
            rd_primed_q   <= 1'b1;
        end
    end

    tof_frame_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_data),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // The RAM read register carries no reset; this flag forces rd_data to 0
    // from reset until the first read has actually been clocked.
    assign rd_data     = rd_primed_q ? ram_rd_data : '0;
    assign frm_valid   = frm_valid_q;
    assign frm_missing = frm_missing_q;
    assign frm_seq     = frm_seq_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_tof_frame_collector.sv
// ---------------------------------------------------------------------------
// tb_tof_frame_collector
// Directed stimulus for tof_frame_collector (8 sensors x 64 zones,
// TIMEOUT=1000). Expected frames (seq, missing, arrival cycle) are queued as
// stimulus is issued; a monitor thread pops and compares each time the DUT
// presents a new frame.
// ---------------------------------------------------------------------------
module tb_tof_frame_collector;

    localparam int N_SENS  = 8;
    localparam int ZONES   = 64;
    localparam int DW      = 16;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  s_sensor;
    logic [5:0]  s_zone;
    logic [15:0] s_data;
    logic [7:0]  sens_mask;
    logic        frm_valid;
    logic        frm_ack;
    logic [7:0]  frm_missing;
    logic [15:0] frm_seq;
    logic [8:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] drop_cnt;

    typedef struct {
        logic [7:0]  missing;
        logic [15:0] seq;
        int          cyc;
    } frm_exp_t;

    frm_exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t, t0, a;

    tof_frame_collector #(
        .N_SENS  (N_SENS),
        .ZONES   (ZONES),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_sensor    (s_sensor),
        .s_zone      (s_zone),
        .s_data      (s_data),
        .sens_mask   (sens_mask),
        .frm_valid   (frm_valid),
        .frm_ack     (frm_ack),
        .frm_missing (frm_missing),
        .frm_seq     (frm_seq),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", nm, act);
        end
    endtask

    task automatic push_exp(input logic [7:0] m, input logic [15:0] s, input int c);
        frm_exp_t e;
        e.missing = m;
        e.seq     = s;
        e.cyc     = c;
        exp_q.push_back(e);
    endtask

    // Detects a new frame: frm_valid rising, or the sequence changing while
    // frm_valid stays high (swap released from HOLD).
    task automatic monitor();
        logic        pv;
        logic [15:0] ps;
        frm_exp_t    e;
        pv = 1'b0;
        ps = 16'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                ps = 16'd0;
            end else begin
                if (frm_valid && (!pv || frm_seq != ps)) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_frame: got seq=%0d missing=0x%0h, required no frame",
                                 frm_seq, frm_missing);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frm_seq", 32'(frm_seq), 32'(e.seq));
                        chk("frm_missing", 32'(frm_missing), 32'(e.missing));
                        chk("frm_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
                pv = frm_valid;
                ps = frm_seq;
            end
        end
    endtask

    task automatic wait_frames(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL frame_wait: got %0d frames pending after %0d cycles, required 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sn, input int zn, input logic [15:0] d, output int tc);
        s_sensor = 3'(sn);
        s_zone   = 6'(zn);
        s_data   = d;
        s_valid  = 1'b1;
        tc       = cyc;
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] xv, output int t_last);
        int tc;
        tc = 0;
        for (int s = 0; s < N_SENS; s++) begin
            for (int z = 0; z < ZONES; z++) begin
                send(s, z, {8'(s), 8'(z)} ^ xv, tc);
            end
        end
        t_last = tc;
    endtask

    task automatic ack();
        frm_ack = 1'b1;
        @(posedge clk);
        #1;
        frm_ack = 1'b0;
    endtask

    task automatic rd_check(input logic [8:0] ad, input logic [15:0] e, input string nm);
        rd_addr = ad;
        @(posedge clk);
        #1;
        chk(nm, 32'(rd_data), 32'(e));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_sensor  = '0;
        s_zone    = '0;
        s_data    = '0;
        sens_mask = '0;
        frm_ack   = 1'b0;
        rd_addr   = '0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_frm_valid", 32'(frm_valid), 32'd0);
        chk("rst_frm_missing", 32'(frm_missing), 32'd0);
        chk("rst_frm_seq", 32'(frm_seq), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: full frame, data = {sensor, zone}
        sens_mask = 8'hFF;
        send_frame(16'h0000, t);
        push_exp(8'h00, 16'd1, t + 2);
        wait_frames(20);
        rd_check(9'h1C5, 16'h0705, "f1_rd_1c5");

        // Frame 2 while frame 1 is unacked -> HOLD
        send_frame(16'hA000, t);
        chk("hold_s_ready", 32'(s_ready), 32'd0);
        s_sensor = 3'd0;
        s_zone   = 6'd0;
        s_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("hold_no_drop", 32'(drop_cnt), 32'd0);
        chk("hold_seq", 32'(frm_seq), 32'd1);
        a = cyc;
        push_exp(8'h00, 16'd2, a + 2);
        ack();
        chk("swap_valid_held", 32'(frm_valid), 32'd1);
        chk("swap_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("post_swap_s_ready", 32'(s_ready), 32'd1);
        chk("post_swap_valid", 32'(frm_valid), 32'd1);
        wait_frames(5);
        rd_check(9'h1C5, 16'hA705, "f2_rd_1c5");
        rd_check(9'h000, 16'hA000, "f2_rd_000");
        ack();
        chk("ack_clears_valid", 32'(frm_valid), 32'd0);

        // Frame 3: timeout with sensor 3 incomplete
        sens_mask = 8'h0F;
        t0 = 0;
        for (int s = 0; s < 3; s++) begin
            for (int z = 0; z < ZONES; z++) begin
                send(s, z, 16'h3000 + 16'(z), t);
                if (s == 0 && z == 0) t0 = t;
            end
        end
        for (int z = 0; z <= 10; z++) begin
            send(3, z, 16'h3300 + 16'(z), t);
        end
        push_exp(8'h08, 16'd3, t0 + 1002);
        wait_frames(1100);
        ack();

        // Frame 4: drops for unmasked sensor and duplicate last zone
        sens_mask = 8'h01;
        for (int i = 0; i < 3; i++) begin
            send(4, i, 16'h4400, t);
        end
        send(0, 63, 16'h1234, t);
        send(0, 63, 16'hDEAD, t);
        push_exp(8'h00, 16'd4, t + 2);
        wait_frames(10);
        repeat (5) @(posedge clk);
        #1;
        chk("drop_cnt_f4", 32'(drop_cnt), 32'd4);
        rd_check(9'h03F, 16'h1234, "f4_rd_03f");
        ack();

        // Frame 5: final write lands on the timeout cycle
        sens_mask = 8'h01;
        send(0, 0, 16'h0500, t0);
        repeat (999) @(posedge clk);
        #1;
        send(0, 63, 16'h0BEE, t);
        push_exp(8'h00, 16'd5, t0 + 1002);
        wait_frames(1100);

        // Reset mid-FILL (frame 5 still valid)
        sens_mask = 8'hFF;
        for (int z = 0; z < 5; z++) begin
            send(0, z, 16'h6000, t);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_frm_valid", 32'(frm_valid), 32'd0);
        chk("arst_frm_seq", 32'(frm_seq), 32'd0);
        chk("arst_frm_missing", 32'(frm_missing), 32'd0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd1);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(16'h5000, t);
        push_exp(8'h00, 16'd1, t + 2);
        wait_frames(20);
        rd_check(9'h1C5, 16'h5705, "f6_rd_1c5");
        chk("f6_drop_cnt", 32'(drop_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
